// File: rtl/mem_d_resp_model.sv
// In-order data-memory responder for the core bench. Requests wait in a bounded
// queue and return tagged ack/error responses after a fixed latency.
module mem_d_resp_model_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [CNT_W-1:0] count
);
    // Flag pushes into a full queue and pops from an empty one.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && (count == CNT_W'(DEPTH))))
                else $error("mem_d_resp_model: queue overflow");
            assert (!(pop && (count == {CNT_W{1'b0}})))
                else $error("mem_d_resp_model: queue underflow");
        end
    end
endmodule

module mem_d_resp_model #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 11,
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 2,
    parameter int MEM_WORDS = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          mem_d_addr_w,
    input  logic [DATA_W-1:0]          mem_d_data_wr_w,
    input  logic                       mem_d_rd_w,
    input  logic [DATA_W/8-1:0]        mem_d_wr_w,
    input  logic                       mem_d_cacheable_w,
    input  logic [TAG_W-1:0]           mem_d_req_tag_w,
    input  logic                       mem_d_flush_w,
    input  logic                       mem_d_invalidate_w,
    input  logic                       mem_d_writeback_w,
    input  logic                       stall_inject_i,
    output logic                       mem_d_accept_w,
    output logic                       mem_d_ack_w,
    output logic [DATA_W-1:0]          mem_d_data_rd_w,
    output logic                       mem_d_error_w,
    output logic [TAG_W-1:0]           mem_d_resp_tag_w,
    output logic [$clog2(DEPTH):0]     outstanding_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(LATENCY + 1);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0]  LAT_C    = AGE_W'(LATENCY);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] WORDS_C  = ADDR_W'(MEM_WORDS);

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BYTES-1:0]  byte_en
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < BYTES; b++) begin
            if (byte_en[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_r [MEM_WORDS];

    logic [TAG_W-1:0]  tag_q_r   [DEPTH];
    logic [DATA_W-1:0] data_q_r  [DEPTH];
    logic              err_q_r   [DEPTH];
    logic [AGE_W-1:0]  age_q_r   [DEPTH];
    logic              valid_q_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              access_s;
    logic              req_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              err_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic [DATA_W-1:0] resp_data_s;
    logic              unused_s;

    assign unused_s = mem_d_cacheable_w;

    // Request decode, acceptance and error classification at the accept edge.
    always_comb begin
        access_s   = mem_d_rd_w | (|mem_d_wr_w);
        req_s      = access_s | mem_d_flush_w | mem_d_invalidate_w | mem_d_writeback_w;
        accept_s   = !stall_inject_i && (count_r < DEPTH_C);
        push_s     = req_s && accept_s;
        word_idx_s = mem_d_addr_w >> OFF_W;
        mem_idx_s  = word_idx_s[IDX_W-1:0];
        err_s      = (mem_d_rd_w && (|mem_d_wr_w)) ||
                     (access_s && (((mem_d_addr_w & OFF_MASK) != {ADDR_W{1'b0}}) ||
                                   (word_idx_s >= WORDS_C)));
        wr_en_s    = push_s && !err_s && (|mem_d_wr_w);
        if (push_s && !err_s && mem_d_rd_w) begin
            resp_data_s = mem_r[mem_idx_s];
        end else begin
            resp_data_s = {DATA_W{1'b0}};
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[mem_idx_s] <= merge_bytes(mem_r[mem_idx_s], mem_d_data_wr_w, mem_d_wr_w);
        end
    end

    // Queue storage, per-entry ageing and pointer/occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                tag_q_r[i]   <= {TAG_W{1'b0}};
                data_q_r[i]  <= {DATA_W{1'b0}};
                err_q_r[i]   <= 1'b0;
                age_q_r[i]   <= {AGE_W{1'b0}};
                valid_q_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (wr_ptr_r == PTR_W'(i))) begin
                    tag_q_r[i]   <= mem_d_req_tag_w;
                    data_q_r[i]  <= resp_data_s;
                    err_q_r[i]   <= err_s;
                    age_q_r[i]   <= AGE_W'(1);
                    valid_q_r[i] <= 1'b1;
                end else if (pop_s && (rd_ptr_r == PTR_W'(i))) begin
                    age_q_r[i]   <= {AGE_W{1'b0}};
                    valid_q_r[i] <= 1'b0;
                end else if (valid_q_r[i] && (age_q_r[i] != LAT_C)) begin
                    age_q_r[i]   <= age_q_r[i] + AGE_W'(1);
                end
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Head entry responds once it has aged to the full latency; outputs idle at zero.
    always_comb begin
        pop_s = valid_q_r[rd_ptr_r] && (age_q_r[rd_ptr_r] == LAT_C);
        if (pop_s) begin
            mem_d_data_rd_w  = data_q_r[rd_ptr_r];
            mem_d_error_w    = err_q_r[rd_ptr_r];
            mem_d_resp_tag_w = tag_q_r[rd_ptr_r];
        end else begin
            mem_d_data_rd_w  = {DATA_W{1'b0}};
            mem_d_error_w    = 1'b0;
            mem_d_resp_tag_w = {TAG_W{1'b0}};
        end
    end

    assign mem_d_accept_w = accept_s;
    assign mem_d_ack_w    = pop_s;
    assign outstanding_o  = count_r;

    mem_d_resp_model_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );
endmodule

// File: tb/tb_mem_d_resp_model.sv
// Randomised scoreboard bench for mem_d_resp_model against a transaction-level
// memory/queue model.
module tb_mem_d_resp_model;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int TAG_W     = 11;
    localparam int DEPTH     = 4;
    localparam int LAT       = 5;
    localparam int MEM_WORDS = 1024;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] mem_d_addr_w = '0;
    logic [DATA_W-1:0] mem_d_data_wr_w = '0;
    logic              mem_d_rd_w = 1'b0;
    logic [3:0]        mem_d_wr_w = '0;
    logic              mem_d_cacheable_w = 1'b0;
    logic [TAG_W-1:0]  mem_d_req_tag_w = '0;
    logic              mem_d_flush_w = 1'b0;
    logic              mem_d_invalidate_w = 1'b0;
    logic              mem_d_writeback_w = 1'b0;
    logic              stall_inject_i = 1'b0;
    logic              mem_d_accept_w;
    logic              mem_d_ack_w;
    logic [DATA_W-1:0] mem_d_data_rd_w;
    logic              mem_d_error_w;
    logic [TAG_W-1:0]  mem_d_resp_tag_w;
    logic [CNT_W-1:0]  outstanding_o;

    mem_d_resp_model #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W),
        .DEPTH(DEPTH), .LATENCY(LAT), .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_d_addr_w(mem_d_addr_w), .mem_d_data_wr_w(mem_d_data_wr_w),
        .mem_d_rd_w(mem_d_rd_w), .mem_d_wr_w(mem_d_wr_w),
        .mem_d_cacheable_w(mem_d_cacheable_w), .mem_d_req_tag_w(mem_d_req_tag_w),
        .mem_d_flush_w(mem_d_flush_w), .mem_d_invalidate_w(mem_d_invalidate_w),
        .mem_d_writeback_w(mem_d_writeback_w), .stall_inject_i(stall_inject_i),
        .mem_d_accept_w(mem_d_accept_w), .mem_d_ack_w(mem_d_ack_w),
        .mem_d_data_rd_w(mem_d_data_rd_w), .mem_d_error_w(mem_d_error_w),
        .mem_d_resp_tag_w(mem_d_resp_tag_w), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              err;
        int                acc_cyc;
    } exp_t;

    exp_t              sb[$];
    int                pend[$];
    logic [DATA_W-1:0] mem_m [int];
    exp_t              got_e;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Expected response from the memory rules; applies writes to the model memory.
    function automatic exp_t model_req(input logic rd, input logic [3:0] be,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [TAG_W-1:0] tag);
        exp_t e;
        int unsigned idx;
        logic [31:0] w;
        e.tag = tag; e.data = 32'h0; e.err = 1'b0; e.acc_cyc = cyc;
        idx = addr / 4;
        if ((rd && be != 4'h0) || ((rd || be != 4'h0) && ((addr % 4) != 0 || idx >= MEM_WORDS))) begin
            e.err = 1'b1;
        end else if (rd) begin
            e.data = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        end else if (be != 4'h0) begin
            w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            mem_m[idx] = w;
        end
        return e;
    endfunction

    // Accept side: occupancy and accept expectations, scoreboard push on transfer.
    always @(negedge clk) begin
        logic req, exp_acc;
        if (!rst_n) begin
            pend.delete();
            check("rst_outstanding", 64'(outstanding_o), 64'd0);
        end else begin
            while (pend.size() > 0 && pend[0] + LAT <= cyc) void'(pend.pop_front());
            req = mem_d_rd_w | (|mem_d_wr_w) | mem_d_flush_w | mem_d_invalidate_w | mem_d_writeback_w;
            exp_acc = !stall_inject_i && (pend.size() < DEPTH);
            check("outstanding", 64'(outstanding_o), 64'(pend.size()));
            check("accept", 64'(mem_d_accept_w), 64'(exp_acc));
            if (req && exp_acc) begin
                sb.push_back(model_req(mem_d_rd_w, mem_d_wr_w, mem_d_addr_w, mem_d_data_wr_w, mem_d_req_tag_w));
                pend.push_back(cyc + 1);
            end
        end
    end

    // Response side: pop and compare on every ack, idle outputs otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            check("rst_ack", 64'(mem_d_ack_w), 64'd0);
        end else if (mem_d_ack_w) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack tag 0x%0h, expected no ack (cycle %0d)", mem_d_resp_tag_w, cyc);
            end else begin
                got_e = sb.pop_front();
                check("resp_tag", 64'(mem_d_resp_tag_w), 64'(got_e.tag));
                check("resp_data", 64'(mem_d_data_rd_w), 64'(got_e.data));
                check("resp_error", 64'(mem_d_error_w), 64'(got_e.err));
                check("resp_latency", 64'(cyc - got_e.acc_cyc), 64'(LAT));
            end
        end else begin
            check("idle_outputs", {20'h0, mem_d_data_rd_w, mem_d_error_w, mem_d_resp_tag_w}, 64'd0);
        end
    end

    task automatic set_idle();
        mem_d_rd_w = 1'b0; mem_d_wr_w = 4'h0; mem_d_addr_w = '0; mem_d_data_wr_w = '0;
        mem_d_req_tag_w = '0; mem_d_flush_w = 1'b0; mem_d_invalidate_w = 1'b0;
        mem_d_writeback_w = 1'b0; mem_d_cacheable_w = 1'b0;
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present a request and hold it until the edge that transfers it.
    task automatic drive(input logic rd, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [TAG_W-1:0] tag,
                         input logic [2:0] maint, input bit rnd_stall);
        int waited;
        logic acc;
        waited = 0;
        mem_d_rd_w = rd; mem_d_wr_w = be; mem_d_addr_w = addr; mem_d_data_wr_w = wdata;
        mem_d_req_tag_w = tag; mem_d_flush_w = maint[0]; mem_d_invalidate_w = maint[1];
        mem_d_writeback_w = maint[2]; mem_d_cacheable_w = 1'($urandom_range(0, 1));
        forever begin
            if (rnd_stall) stall_inject_i = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            acc = mem_d_accept_w;
            @(posedge clk); #1;
            if (acc) break;
            waited++;
            if (waited > 60) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got no accept in 60 cycles, expected accept (tag 0x%0h)", tag);
                break;
            end
        end
        stall_inject_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] a;
        set_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        drive(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 11'd5, 3'b000, 0);
        drive(1'b1, 4'h0, 32'h10, 32'h0, 11'd6, 3'b000, 0);
        idle(LAT + 3);

        drive(1'b0, 4'hF, 32'h10, 32'h11223344, 11'd1, 3'b000, 0);
        drive(1'b0, 4'b0010, 32'h10, 32'h0000AB00, 11'd2, 3'b000, 0);
        drive(1'b1, 4'h0, 32'h10, 32'h0, 11'd3, 3'b000, 0);
        idle(LAT + 3);

        for (int t = 0; t < 6; t++) drive(1'b1, 4'h0, 32'h10, 32'h0, 11'(t), 3'b000, 0);
        idle(LAT + 4);

        drive(1'b1, 4'h0, 32'h2, 32'h0, 11'h10, 3'b000, 0);
        drive(1'b1, 4'h0, 32'(4 * MEM_WORDS), 32'h0, 11'h11, 3'b000, 0);
        drive(1'b1, 4'h1, 32'h10, 32'hFFFFFFFF, 11'h12, 3'b000, 0);
        drive(1'b1, 4'h0, 32'h10, 32'h0, 11'h13, 3'b000, 0);
        drive(1'b0, 4'h4, 32'h11, 32'h00FF0000, 11'h14, 3'b000, 0);
        idle(LAT + 3);

        mem_d_flush_w = 1'b1; mem_d_req_tag_w = 11'h7FF; stall_inject_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        stall_inject_i = 1'b0;
        @(negedge clk);
        check("stall_release_accept", 64'(mem_d_accept_w), 64'd1);
        @(posedge clk); #1;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 11'h100, 3'b010, 0);
        drive(1'b0, 4'h0, 32'h0, 32'h0, 11'h101, 3'b100, 0);
        drive(1'b0, 4'h0, 32'h0, 32'h0, 11'h102, 3'b111, 0);
        idle(LAT + 3);

        for (int w = 0; w < 16; w++) drive(1'b0, 4'hF, 32'(4 * w), $urandom, 11'(w), 3'b000, 0);
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            a = 32'(4 * $urandom_range(0, 15));
            case (k)
                0, 1, 2, 3: drive(1'b1, 4'h0, a, $urandom, 11'($urandom), 3'b000, 1);
                4, 5, 6:    drive(1'b0, 4'($urandom_range(1, 15)), a, $urandom, 11'($urandom), 3'b000, 1);
                7:          drive(1'b0, 4'h0, a, $urandom, 11'($urandom), 3'($urandom_range(1, 7)), 1);
                8:          drive(1'($urandom_range(0, 1)), 4'h3, a | 32'($urandom_range(1, 3)), $urandom, 11'($urandom), 3'b000, 1);
                default:    drive(1'b1, 4'($urandom_range(0, 15)), 32'(4 * MEM_WORDS) + a, $urandom, 11'($urandom), 3'b000, 1);
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(LAT + 3);

        drive(1'b0, 4'hF, 32'h40, 32'hCAFEF00D, 11'h20, 3'b000, 0);
        idle(LAT + 3);
        drive(1'b1, 4'h0, 32'h40, 32'h0, 11'h21, 3'b000, 0);
        drive(1'b1, 4'h0, 32'h40, 32'h0, 11'h22, 3'b000, 0);
        drive(1'b1, 4'h0, 32'h40, 32'h0, 11'h23, 3'b000, 0);
        set_idle();
        rst_n = 1'b0;
        #1;
        check("async_rst_outstanding", 64'(outstanding_o), 64'd0);
        check("async_rst_ack", 64'(mem_d_ack_w), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(LAT + 6);
        drive(1'b1, 4'h0, 32'h40, 32'h0, 11'h24, 3'b000, 0);
        idle(LAT + 3);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
